// File: rtl/dm_ctrl_if.sv
// Request/response bundle between the multicycle MIPS datapath and the data-memory controller.
interface dm_ctrl_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [2:0]  DMop;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] memword;
   logic [1:0]  addr_lo;

   modport master (
      output req, we, addr, DMop, wdata,
      input  busy, done, err, memword, addr_lo
   );

   modport slave (
      input  req, we, addr, DMop, wdata,
      output busy, done, err, memword, addr_lo
   );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory controller: word RAM with load, word store and read-modify-write sub-word store.
// Optional alignment checking is enabled by defining DMCTRL_ALIGN_CHECK_EN.
module dm_ctrl #(
   parameter int ADDR_W = 10
) (
   input logic     clk,
   input logic     rst_n,
   dm_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MRG,
      S_WR,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic                err_q, err_d;
   logic [31:0]         memword_q, memword_d;
   logic [1:0]          addr_lo_q, addr_lo_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [1:0]          lo_q, lo_d;
   logic [1:0]          size_q, size_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         merge_q, merge_d;

   logic [31:0]         mem [2**ADDR_W];
   logic [31:0]         rd_word;
   logic                mem_we;
   logic [31:0]         mem_wdata;
   logic                mis;
   logic                unused_bits;

   // Byte lane replacement; halfwords select their lane with lo[1] only.
   function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic        is_half,
                                              input logic [1:0]  lo);
      logic [31:0] r;
      r = word;
      if (is_half) begin
         if (lo[1]) r[31:16] = wd;
         else       r[15:0]  = wd;
      end else begin
         case (lo)
            2'd0:    r[7:0]   = wd[7:0];
            2'd1:    r[15:8]  = wd[7:0];
            2'd2:    r[23:16] = wd[7:0];
            default: r[31:24] = wd[7:0];
         endcase
      end
      return r;
   endfunction

`ifdef DMCTRL_ALIGN_CHECK_EN
   assign mis = ((bus.DMop[1:0] == 2'b01) && bus.addr[0]) ||
                (bus.DMop[1] && (bus.addr[1:0] != 2'b00));
`else
   assign mis = 1'b0;
`endif

   // Unsigned flag and address bits above the index belong to other stages.
   assign unused_bits = ^{bus.DMop[2], bus.addr[31:ADDR_W+2]};

   assign rd_word = mem[idx_q];

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      memword_d = memword_q;
      addr_lo_d = addr_lo_q;
      we_d      = we_q;
      idx_d     = idx_q;
      lo_d      = lo_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      merge_d   = merge_q;
      mem_we    = 1'b0;
      mem_wdata = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               idx_d   = bus.addr[ADDR_W+1:2];
               lo_d    = bus.addr[1:0];
               size_d  = bus.DMop[1:0];
               wdata_d = bus.wdata;
               err_d   = mis;
               if (mis)                         state_d = S_DONE;
               else if (!bus.we || !bus.DMop[1]) state_d = S_RD;
               else                             state_d = S_WR;
            end
         end
         S_RD: begin
            if (!we_q) begin
               memword_d = rd_word;
               addr_lo_d = lo_q;
               state_d   = S_DONE;
            end else begin
               merge_d = rd_word;
               state_d = S_MRG;
            end
         end
         S_MRG: begin
            mem_we    = 1'b1;
            mem_wdata = merge_lane(merge_q, wdata_q[15:0], size_q == 2'b01, lo_q);
            state_d   = S_DONE;
         end
         S_WR: begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
            state_d   = S_DONE;
         end
         S_DONE: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         err_q     <= 1'b0;
         memword_q <= '0;
         addr_lo_q <= '0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         memword_q <= memword_d;
         addr_lo_q <= addr_lo_d;
      end
   end

   always_ff @(posedge clk) begin
      we_q    <= we_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
   end

   // Reset on the committing edge aborts the write.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) mem[idx_q] <= mem_wdata;
   end

   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.err     = (state_q == S_DONE) && err_q;
   assign bus.memword = memword_q;
   assign bus.addr_lo = addr_lo_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl against a little-endian byte-array memory model.
module tb_dm_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [7:0]  ref_b [4096];
   logic [31:0] exp_mw;
   logic [1:0]  exp_lo;

   dm_ctrl_if ifc ();

   dm_ctrl #(.ADDR_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge with the controller idle; returns at the falling edge of the idle cycle.
   task automatic run_op(input bit w, input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
      logic [1:0] sz;
      bit         mis;
      int         lat;
      int         n;
      bit         seen;
      int         b;
      sz  = op[1:0];
      mis = 1'b0;
`ifdef DMCTRL_ALIGN_CHECK_EN
      if (sz == 2'b01 && a[0]) mis = 1'b1;
      if (sz[1] && a[1:0] != 2'b00) mis = 1'b1;
`endif
      lat = mis ? 1 : ((w && !sz[1]) ? 3 : 2);
      ifc.req = 1'b1; ifc.we = w; ifc.addr = a; ifc.DMop = op; ifc.wdata = d;
      @(posedge clk);
      #1;
      ifc.req = 1'b0; ifc.we = 1'($urandom); ifc.addr = $urandom;
      ifc.DMop = 3'($urandom); ifc.wdata = $urandom;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 8) begin
         @(negedge clk);
         n++;
         if (n == 1) check("busy_c1", 32'(ifc.busy), 32'd1);
         if (ifc.done) seen = 1'b1;
      end
      check("latency", n, lat);
      check("err", 32'(ifc.err), 32'(mis));
      b = int'(a[11:0]);
      if (!mis) begin
         if (w) begin
            case (sz)
               2'b00: ref_b[b] = d[7:0];
               2'b01: begin
                  b = b & ~1;
                  ref_b[b]   = d[7:0];
                  ref_b[b+1] = d[15:8];
               end
               default: begin
                  b = b & ~3;
                  for (int k = 0; k < 4; k++) ref_b[b+k] = d[8*k +: 8];
               end
            endcase
         end else begin
            b = b & ~3;
            exp_mw = {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
            exp_lo = a[1:0];
         end
      end
      @(negedge clk);
      check("busy_idle", 32'(ifc.busy), 32'd0);
      check("done_idle", 32'(ifc.done), 32'd0);
      check("err_idle", 32'(ifc.err), 32'd0);
      check("memword", ifc.memword, exp_mw);
      check("addr_lo", 32'(ifc.addr_lo), 32'(exp_lo));
   endtask

   initial begin
      int ndone;
      checks = 0;
      errors = 0;
      exp_mw = '0;
      exp_lo = '0;
      rst_n = 1'b0;
      ifc.req = 1'b0; ifc.we = 1'b0; ifc.addr = '0; ifc.DMop = '0; ifc.wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(ifc.busy), 32'd0);
      check("rst_done", 32'(ifc.done), 32'd0);
      check("rst_err", 32'(ifc.err), 32'd0);
      check("rst_memword", ifc.memword, 32'd0);
      check("rst_addr_lo", 32'(ifc.addr_lo), 32'd0);
      rst_n = 1'b1;

      run_op(1'b1, 32'h10, 3'b011, 32'hDEADBEEF);
      run_op(1'b0, 32'h10, 3'b011, 32'h0);
      check("tp_word", ifc.memword, 32'hDEADBEEF);

      run_op(1'b1, 32'h20, 3'b011, 32'h11223344);
      run_op(1'b1, 32'h21, 3'b000, 32'hFFFF_FFAB);
      run_op(1'b0, 32'h21, 3'b100, 32'h0);
      check("tp_byte", ifc.memword, 32'h1122AB44);
      check("tp_byte_lo", 32'(ifc.addr_lo), 32'd1);

      run_op(1'b1, 32'h20, 3'b011, 32'h11223344);
      run_op(1'b1, 32'h22, 3'b001, 32'h1234CAFE);
      run_op(1'b0, 32'h20, 3'b011, 32'h0);
      check("tp_half", ifc.memword, 32'hCAFE3344);
`ifdef DMCTRL_ALIGN_CHECK_EN
      run_op(1'b1, 32'h23, 3'b001, 32'h0000BEEF);
      run_op(1'b0, 32'h20, 3'b011, 32'h0);
      check("tp_misaligned", ifc.memword, 32'hCAFE3344);
`endif

      // Request while busy must be dropped.
      run_op(1'b1, 32'h34, 3'b011, 32'h0BADF00D);
      ifc.req = 1'b1; ifc.we = 1'b1; ifc.addr = 32'h30; ifc.DMop = 3'b011; ifc.wdata = 32'h12345678;
      @(posedge clk);
      #1 ifc.req = 1'b0;
      @(negedge clk);
      ifc.req = 1'b1; ifc.we = 1'b1; ifc.addr = 32'h34; ifc.DMop = 3'b000; ifc.wdata = 32'h99;
      @(posedge clk);
      #1 ifc.req = 1'b0;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ifc.done) ndone++;
      end
      check("ignore_done_count", ndone, 1);
      for (int k = 0; k < 4; k++) ref_b[32'h30 + k] = 8'(32'h12345678 >> (8 * k));
      run_op(1'b0, 32'h30, 3'b011, 32'h0);
      run_op(1'b0, 32'h34, 3'b011, 32'h0);
      check("ignore_untouched", ifc.memword, 32'h0BADF00D);

      // Reset in the merge cycle aborts the write.
      run_op(1'b1, 32'h40, 3'b011, 32'h55555555);
      ifc.req = 1'b1; ifc.we = 1'b1; ifc.addr = 32'h41; ifc.DMop = 3'b000; ifc.wdata = 32'hAA;
      @(posedge clk);
      #1 ifc.req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mrg_busy", 32'(ifc.busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", 32'(ifc.busy), 32'd0);
      check("abort_done", 32'(ifc.done), 32'd0);
      check("abort_err", 32'(ifc.err), 32'd0);
      check("abort_memword", ifc.memword, 32'd0);
      check("abort_addr_lo", 32'(ifc.addr_lo), 32'd0);
      exp_mw = '0;
      exp_lo = '0;
      rst_n = 1'b1;
      run_op(1'b0, 32'h40, 3'b011, 32'h0);
      check("abort_word_kept", ifc.memword, 32'h55555555);

      // Index 2^ADDR_W wraps to index 0.
      run_op(1'b1, 32'h1000, 3'b011, 32'hA5A50F0F);
      run_op(1'b0, 32'h0, 3'b011, 32'h0);
      check("alias", ifc.memword, 32'hA5A50F0F);

      for (int i = 0; i < 16; i++) run_op(1'b1, 32'(4 * i), 3'b011, $urandom);
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         run_op(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Data-memory controller for the multicycle MIPS datapath. Owns the word-organised data RAM, serves one load or store per request through a busy/done handshake, and performs read-modify-write for byte and halfword stores. Sits directly upstream of the load-extension stage: it delivers the raw aligned 32-bit word (`memword`) and the registered byte offset (`addr_lo`), which that stage uses to select and sign/zero-extend the loaded data.

## Interface
- `ADDR_W`, default 10: word-index width; the RAM holds 2^ADDR_W 32-bit words.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req`  in  1: request strobe; sampled only in IDLE.
- `we`  in  1: 1 selects a store, 0 selects a load.
- `addr`  in  32: byte address; the word index is `addr[ADDR_W+1:2]`, upper bits are ignored so the index wraps.
- `DMop`  in  3: `[1:0]` gives size: 00 byte, 01 half, 11 word, 10 reserved and treated as word. `[2]` is the unsigned flag; it is ignored here and used only by the extension stage.
- `wdata`  in  32: store data, right-justified; byte uses `[7:0]`, half uses `[15:0]`.
- `busy`  out  1: high in every non-IDLE state.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: misalignment flag, valid while `done`=1.
- `memword`  out  32: raw word from the last completed load.
- `addr_lo`  out  2: `addr[1:0]` of the last completed load.

## Operation
- States: IDLE, RD, MRG, WR, DONE.
- On `req`=1 in IDLE, capture `we`, `addr`, `DMop` and `wdata`, then branch:
  - load → RD
  - byte or half store → RD
  - word store → WR
  - misaligned access (see Configuration) → DONE with `err`=1
- `req` while `busy`=1 is ignored; it is neither queued nor errored.
- RD reads the array at the captured index.
  - Load: at the end of RD, `memword` is loaded with the read word and `addr_lo` with the captured `addr[1:0]`; next state DONE.
  - Sub-word store: the read word is held in a merge register; next state MRG.
- MRG replaces one lane of the held word and writes the result back at the end of MRG; next state DONE.
  - Byte: lane `addr[1:0]` (bits 8k+7:8k) is replaced by `wdata[7:0]`.
  - Half: `addr[1]`=0 replaces `[15:0]`, 1 replaces `[31:16]`, with `wdata[15:0]`.
  - All other bits are preserved.
- WR writes `wdata` to the full word at the end of WR; next state DONE.
- DONE drives `done`=1, then returns to IDLE.
- `memword` and `addr_lo` change only at the end of a load's RD state and hold across stores and errors.
- A store never alters `memword`, even when it hits the same address.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state IDLE
  - `busy`=0, `done`=0, `err`=0
  - `memword`=0, `addr_lo`=0
  - RAM contents are not cleared.
- Reset during RD, MRG or WR aborts the operation; no array write occurs on that edge.
- Latency counts from the `req` edge (cycle 0) to the cycle `done`=1:
  - load: 2 cycles
  - word store: 2 cycles
  - byte or half store: 3 cycles
  - error: 1 cycle
- `busy` goes high in cycle 1 and falls when the FSM re-enters IDLE, the cycle after `done`.
- The earliest next request is accepted on the edge at the end of that IDLE cycle.
- The write commits on the edge ending WR or MRG. A load issued immediately after a store reads the new data.
- `err` is 0 whenever `done`=0.

## Configuration
- `DMCTRL_ALIGN_CHECK_EN` defined:
  - Halfword requests with `addr[0]`=1 are misaligned.
  - Word or reserved-size requests with `addr[1:0]`≠0 are misaligned.
  - A misaligned request goes IDLE→DONE with `err`=1.
  - No array access occurs, and `memword` and `addr_lo` are unchanged.
- Undefined:
  - No check is made and `err` is tied to 0.
  - Halfword ignores `addr[0]`; word ignores `addr[1:0]`.
  - Misaligned requests complete normally at their natural latency.

## Test plan
- Reset, then word store of 0xDEADBEEF to addr 0x10, then load word from 0x10 → `done` at cycle 2 of each request; `memword`=0xDEADBEEF, `addr_lo`=0.
- With word 0x11223344 at 0x20, byte store `wdata`=0xAB to addr 0x21 → `done` at cycle 3. A following load of 0x21 gives `memword`=0x1122AB44 and `addr_lo`=1.
- Half store `wdata`=0xCAFE to 0x22 over 0x11223344 → reload gives 0xCAFE3344. With the macro defined, the same store to 0x23 gives `err`=1 at cycle 1 and the word stays unchanged.
- Pulse `req` (a store) while `busy`=1 → ignored; exactly one `done` pulse and one write occur.
- Assert `rst_n`=0 during MRG of a byte store to a word holding 0x55555555 → the word is still 0x55555555 after reset; all outputs are 0.
- Word store to index 2^ADDR_W → aliases index 0; a load of addr 0 returns the stored value.
